sd_rrarb_pkt: RTL
=================

Name: sd_rrarb_pkt

Overview:
- Round-robin, packet-aware arbiter that merges N srdy/drdy producer streams into one output stream.
- The output stream normally feeds a shared sd_fifo_c.
- A single-entry registered output stage decouples arbitration timing from the downstream drdy.
- Once an input wins and sends a non-final beat, it keeps the grant until its end-of-packet beat transfers, so packets are never interleaved.

Parameters:
- inputs, 4, number of requesting producer ports (2..16).
- width, 8, data width per port.
- isz, $clog2(inputs), width of the grant index.
- pkt_mode, 1; 1 = hold grant until eop transfers; 0 = re-arbitrate every beat (eop ignored for locking).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-high.
- c_srdy  input  inputs  per-port source ready.
- c_drdy  output  inputs  per-port destination ready (one-hot or zero).
- c_data  input  inputs*width  port i data at bits [i*width +: width].
- c_eop  input  inputs  per-port end-of-packet flag, qualified by c_srdy.
- p_srdy  output  1  output valid (registered).
- p_drdy  input  1  downstream ready.
- p_data  output  width  output data (registered).
- p_eop  output  1  eop of the beat held in p_data.
- p_grant  output  isz  source port index of the beat in p_data.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - p_srdy=0, p_data=0, p_eop=0, p_grant=0.
  - state=ARB.
  - last winner pointer = inputs-1, so port 0 has first priority.
  - c_drdy=0 during the reset cycle.
- Output stage:
  - load = (!p_srdy | p_drdy).
  - c_drdy[i] = load & (i == sel) & c_srdy[i]. At most one bit is set.
  - Transfer on port i when c_srdy[i] & c_drdy[i]. On the next edge: p_data=c_data[i], p_eop=c_eop[i], p_grant=i, p_srdy=1.
  - If p_srdy & p_drdy and no input transfers: p_srdy=0 next cycle. p_data, p_eop and p_grant hold their values.
  - Latency is 1 cycle from input transfer to p_srdy. Full throughput: one beat per cycle while p_drdy=1.
  - No combinational path from p_drdy to p_data. The path from p_drdy to c_drdy is permitted.
- State ARB:
  - sel = first i with c_srdy[i]=1, searching from (last+1) mod inputs upward with wrap.
  - If no c_srdy bit is set: no transfer; last is unchanged.
  - On a transfer from sel: last <= sel.
  - If pkt_mode=1 and c_eop[sel]=0: go to LOCK with lock_idx <= sel. Otherwise stay in ARB.
- State LOCK:
  - sel = lock_idx. Other ports see c_drdy=0 even if the locked port has c_srdy=0 (a bubble is permitted; the grant is not surrendered).
  - A transfer with c_eop[lock_idx]=1 returns to ARB, last <= lock_idx. A transfer with c_eop=0 stays in LOCK.
- Stall: when load=0, no transfer occurs, sel is not committed, and last and state do not change.
- Single-beat packets (eop=1 on the first beat) never enter LOCK.
- pkt_mode=0: state never leaves ARB.
- Reset mid-packet: the partial packet is abandoned and the held output beat is dropped (p_srdy=0). The downstream consumer is responsible for packet recovery.
- Widths: pointer arithmetic is modulo inputs. For non-power-of-2 inputs, the wrap from inputs-1 goes to 0 explicitly, never through an index ≥ inputs.

Test Plan (inputs=4, width=8, pkt_mode=1 unless stated):
- Reset, then all four ports present eop=1 beats continuously with p_drdy=1 → grant order 0,1,2,3,0,…; p_grant increments every cycle; p_data = port ID, with no gaps after the first cycle.
- Port 1 sends a 3-beat packet (eop on beat 3) while ports 0 and 2 request → p_grant = 1,1,1 contiguous, then 2, then 0 (round-robin resumes after 1); no interleave.
- Locked port 3 drops c_srdy for 2 cycles mid-packet while port 0 requests → c_drdy[0] stays 0; p_srdy=0 during the bubble; port 3 completes; port 0 wins next.
- p_drdy held 0 for 5 cycles with p_srdy=1 → p_data stable, c_drdy all 0, last unchanged; on release the next beat follows in the next cycle (back-to-back).
- Assert reset mid-packet (port 2, beat 2 of 4) → next cycle p_srdy=0 and state=ARB; port 0 wins first after reset.
- pkt_mode=0: port 1 sends eop=0 beats with ports 1 and 2 requesting → grants alternate 1,2,1,2.
- Formal: per-port data order preserved (fv_fifo scoreboard per source), at most one c_drdy bit set, no interleaving inside a packet.

Source files
------------

// File: rtl/sd_rrarb_pkt.sv
// sd_rrarb_pkt: packet-aware round-robin arbiter merging several srdy/drdy
// producer streams into one registered output stream. In packet mode a port
// that sends a non-final beat keeps the grant until its eop beat transfers.
module sd_rrarb_pkt #(
    parameter int inputs   = 4,
    parameter int width    = 8,
    parameter int isz      = $clog2(inputs),
    parameter int pkt_mode = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [inputs-1:0]         c_srdy,
    output logic [inputs-1:0]         c_drdy,
    input  logic [inputs*width-1:0]   c_data,
    input  logic [inputs-1:0]         c_eop,
    output logic                      p_srdy,
    input  logic                      p_drdy,
    output logic [width-1:0]          p_data,
    output logic                      p_eop,
    output logic [isz-1:0]            p_grant
);

    typedef enum logic {ARB, LOCK} state_t;

    state_t           state_q, state_d;
    logic [isz-1:0]   last_q, last_d;
    logic [isz-1:0]   lock_idx_q, lock_idx_d;
    logic             p_srdy_q, p_srdy_d;
    logic [width-1:0] p_data_q, p_data_d;
    logic             p_eop_q, p_eop_d;
    logic [isz-1:0]   p_grant_q, p_grant_d;

    logic [isz-1:0]   arb_sel;
    logic             arb_found;
    logic [isz-1:0]   sel;
    logic             req_ok;
    logic             load;
    logic             xfer;
    logic [width-1:0] sel_data;
    logic             sel_eop;
    int               idx;

    // Round-robin search starting just after the last winner, wrapping explicitly at inputs-1.
    always_comb begin
        arb_sel   = '0;
        arb_found = 1'b0;
        idx       = 0;
        for (int k = 1; k <= inputs; k++) begin
            idx = int'(last_q) + k;
            if (idx >= inputs) begin
                idx = idx - inputs;
            end
            if (!arb_found && c_srdy[idx[isz-1:0]]) begin
                arb_sel   = isz'(idx);
                arb_found = 1'b1;
            end
        end
    end

    // Handshake: the selected port may transfer whenever the output register can accept a beat.
    always_comb begin
        load     = !p_srdy_q || p_drdy;
        sel      = (state_q == LOCK) ? lock_idx_q : arb_sel;
        req_ok   = (state_q == LOCK) ? c_srdy[lock_idx_q] : arb_found;
        xfer     = !reset && load && req_ok;
        sel_data = c_data[int'(sel)*width +: width];
        sel_eop  = c_eop[sel];
        c_drdy   = '0;
        if (xfer) begin
            c_drdy[sel] = 1'b1;
        end
    end

    // Next-state: capture a transferred beat, update the fairness pointer and the packet lock.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_idx_d = lock_idx_q;
        p_srdy_d   = p_srdy_q;
        p_data_d   = p_data_q;
        p_eop_d    = p_eop_q;
        p_grant_d  = p_grant_q;
        if (xfer) begin
            p_srdy_d  = 1'b1;
            p_data_d  = sel_data;
            p_eop_d   = sel_eop;
            p_grant_d = sel;
            last_d    = sel;
            if ((pkt_mode != 0) && !sel_eop) begin
                state_d    = LOCK;
                lock_idx_d = sel;
            end else begin
                state_d = ARB;
            end
        end else if (p_srdy_q && p_drdy) begin
            p_srdy_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any partial packet and drops the held beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            last_q     <= isz'(inputs - 1);
            lock_idx_q <= '0;
            p_srdy_q   <= 1'b0;
            p_data_q   <= '0;
            p_eop_q    <= 1'b0;
            p_grant_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_idx_q <= lock_idx_d;
            p_srdy_q   <= p_srdy_d;
            p_data_q   <= p_data_d;
            p_eop_q    <= p_eop_d;
            p_grant_q  <= p_grant_d;
        end
    end

    assign p_srdy  = p_srdy_q;
    assign p_data  = p_data_q;
    assign p_eop   = p_eop_q;
    assign p_grant = p_grant_q;

endmodule
